// File: rtl/dualmem_narrow_reader_if.sv
// ---------------------------------------------------------------------------
// dualmem_narrow_reader_if
//
// Bundles the signals of the narrow reader: command channel, wide-port
// memory read channel, 16-bit output stream and status.
//
// Modports:
//   master : the reader itself. Drives cmd_ready, mem_en, mem_addr,
//            out_valid, out_data, out_last, busy and done. Samples
//            cmd_valid, cmd_addr, cmd_len, mem_rdata and out_ready.
//   slave  : the surroundings (command source, buffer wide port,
//            16-bit consumer). Signal directions are the mirror of master.
//
// Parameters:
//   AW   : wide-port word address width
//   LENW : command length width in 64-bit words
// ---------------------------------------------------------------------------
interface dualmem_narrow_reader_if #(
  parameter int AW   = 11,
  parameter int LENW = 12
);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic [LENW-1:0] cmd_len;

  logic            mem_en;
  logic [AW-1:0]   mem_addr;
  logic [63:0]     mem_rdata;

  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_data;
  logic            out_last;

  logic            busy;
  logic            done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, mem_rdata, out_ready,
    output cmd_ready, mem_en, mem_addr, out_valid, out_data, out_last,
           busy, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, mem_rdata, out_ready,
    input  cmd_ready, mem_en, mem_addr, out_valid, out_data, out_last,
           busy, done
  );

endinterface

// File: rtl/dualmem_narrow_reader.sv
// ---------------------------------------------------------------------------
// dualmem_narrow_reader
//
// Streaming reader on the 64-bit wide port of the 16/64 widening dual-port
// buffer. A command (start word address, length in 64-bit words) is turned
// into a sequence of wide-port reads; every returned word is buffered in a
// small prefetch FIFO and handed out as four 16-bit beats, lane 0 (bits
// 15:0) first, on a valid/ready stream.
//
// Ports:
//   clk  : single clock
//   rstn : asynchronous active-low reset
//   bus  : dualmem_narrow_reader_if.master
//          cmd_valid/cmd_ready/cmd_addr/cmd_len : command handshake
//          mem_en/mem_addr/mem_rdata            : wide-port read, data one
//                                                  cycle after mem_en
//          out_valid/out_ready/out_data/out_last: 16-bit beat stream
//          busy                                 : high while not idle
//          done                                 : one-cycle completion pulse
//
// Parameters:
//   AW         : wide-port word address width (address wraps mod 2^AW)
//   LENW       : command length width in 64-bit words
//   FIFO_DEPTH : prefetch FIFO entries (at least 2 for full throughput)
// ---------------------------------------------------------------------------
module dualmem_narrow_reader #(
  parameter int AW         = 11,
  parameter int LENW       = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  dualmem_narrow_reader_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int PTRW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int BW   = LENW + 2;

  localparam logic [CNTW:0]   DEPTH_C  = (CNTW + 1)'(FIFO_DEPTH);
  localparam logic [PTRW-1:0] PTR_LAST = PTRW'(FIFO_DEPTH - 1);

  state_t          state;
  state_t          next_state;

  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   last_addr_q;
  logic [LENW-1:0] rd_remain_q;
  logic [BW-1:0]   beats_remain_q;
  logic            inflight_q;

  logic [63:0]     fifo_mem [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr_q;
  logic [PTRW-1:0] rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic [1:0]      lane_q;

  logic            cmd_ready_c;
  logic            issue_c;
  logic            busy_c;
  logic            done_c;

  logic            cmd_accept;
  logic            out_valid_c;
  logic            beat_fire;
  logic            push;
  logic            pop;
  logic            last_beat;
  logic            credit_ok;
  logic [CNTW:0]   occupancy;
  logic [63:0]     head_word;

  // Pointer advance that also works for depths that are not a power of two.
  function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTRW'(1);
  endfunction

  // Credit is based on the registered count plus the read still in flight,
  // so a pop in this cycle only frees a slot from the next cycle on. This
  // guarantees that returning data always finds room in the FIFO.
  assign occupancy   = {1'b0, count_q} + {{CNTW{1'b0}}, inflight_q};
  assign credit_ok   = (occupancy < DEPTH_C);

  assign out_valid_c = (count_q != '0);
  assign beat_fire   = out_valid_c & bus.out_ready;
  assign pop         = beat_fire & (lane_q == 2'd3);
  assign push        = inflight_q;
  assign last_beat   = out_valid_c & (beats_remain_q == BW'(1));
  assign cmd_accept  = cmd_ready_c & bus.cmd_valid;
  assign head_word   = fifo_mem[rd_ptr_q];

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control outputs. Reads are only issued in RUN while
  // words remain and the FIFO has credit; the transfer ends on the
  // handshake of the final beat, and DONE lasts exactly one cycle.
  always_comb begin
    next_state  = state;
    cmd_ready_c = 1'b0;
    issue_c     = 1'b0;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          next_state = (bus.cmd_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy_c = 1'b1;
        if ((rd_remain_q != '0) && credit_ok) begin
          issue_c = 1'b1;
        end
        if (beat_fire && last_beat) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_c     = 1'b1;
        done_c     = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Command latching, read address generation, FIFO bookkeeping and lane
  // tracking. The in-flight flag is cleared by reset so that the read data
  // of an aborted transfer is never pushed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q         <= '0;
      last_addr_q    <= '0;
      rd_remain_q    <= '0;
      beats_remain_q <= '0;
      inflight_q     <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      lane_q         <= 2'd0;
    end else begin
      if (cmd_accept) begin
        addr_q         <= bus.cmd_addr;
        rd_remain_q    <= bus.cmd_len;
        beats_remain_q <= {bus.cmd_len, 2'b00};
      end

      if (issue_c) begin
        last_addr_q <= addr_q;
        addr_q      <= addr_q + AW'(1);
        rd_remain_q <= rd_remain_q - LENW'(1);
      end

      inflight_q <= issue_c;

      if (push) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end

      if (push && !pop) begin
        count_q <= count_q + CNTW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNTW'(1);
      end

      // Lane wraps 3 -> 0 naturally, in step with the pop.
      if (beat_fire) begin
        lane_q         <= lane_q + 2'd1;
        beats_remain_q <= beats_remain_q - BW'(1);
      end
    end
  end

  // Prefetch storage; contents need no reset because count_q guards them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.mem_rdata;
    end
  end

  // mem_addr shows the issuing address during mem_en and otherwise keeps
  // the last address that was issued.
  assign bus.cmd_ready = cmd_ready_c;
  assign bus.mem_en    = issue_c;
  assign bus.mem_addr  = issue_c ? addr_q : last_addr_q;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_valid_c ? head_word[{lane_q, 4'b0000} +: 16] : 16'h0000;
  assign bus.out_last  = last_beat;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;

endmodule

// File: tb/tb_dualmem_narrow_reader.sv
// ---------------------------------------------------------------------------
// tb_dualmem_narrow_reader
//
// Self-checking bench for dualmem_narrow_reader. A behavioural memory answers
// wide-port reads one cycle later; expected beats and read addresses are
// built from the command and the memory contents as plain word/lane lists.
// A negedge monitor records every read, beat, accept and done pulse and
// checks the per-cycle rules (read credit, address hold, stall stability).
// ---------------------------------------------------------------------------
module tb_dualmem_narrow_reader;

  localparam int AW    = 11;
  localparam int LENW  = 12;
  localparam int DEPTH = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  always #5 clk = ~clk;

  dualmem_narrow_reader_if #(.AW(AW), .LENW(LENW)) bus ();

  dualmem_narrow_reader #(
    .AW(AW), .LENW(LENW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] mem [2**AW];

  int ready_mode = 0;
  int rphase     = 0;
  int cyc        = 0;

  // Observations.
  logic [AW-1:0] iss_q[$];
  int            iss_cyc_q[$];
  logic [15:0]   beat_q[$];
  logic          last_q[$];
  int            beat_cyc_q[$];
  int            acc_cyc_q[$];
  logic          acc_busy_q[$];
  int            done_cyc_q[$];

  // Expectations.
  logic [AW-1:0] exp_addr_q[$];
  logic [15:0]   exp_beat_q[$];
  logic          exp_last_q[$];

  // Monitor model state: words issued / fully consumed, current command.
  int            m_issued = 0;
  int            m_popped = 0;
  int            m_len = 0;
  int            m_len_issued = 0;
  int            m_beat = 0;
  bit            m_run = 0;
  logic [AW-1:0] m_last_addr = '0;
  bit            stall_prev = 0;
  logic [15:0]   stall_data = '0;

  // Wide-port memory: data for a read appears in the following cycle.
  initial begin
    logic          en;
    logic [AW-1:0] a;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      en = bus.mem_en;
      a  = bus.mem_addr;
      @(posedge clk);
      #1;
      bus.mem_rdata = en ? mem[a] : {$urandom(), $urandom()};
    end
  end

  // Consumer ready pattern: 0 always ready, 1 one-on/two-off, 2 random.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          bus.out_ready = (rphase == 0);
          rphase = (rphase + 1) % 3;
        end
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Per-cycle monitor.
  always @(negedge clk) begin
    bit exp_en;
    cyc++;
    if (!rstn) begin
      m_issued = 0; m_popped = 0; m_len = 0; m_len_issued = 0; m_beat = 0;
      m_run = 0; m_last_addr = '0; stall_prev = 0;
    end else begin
      exp_en = m_run && (m_len_issued < m_len) && ((m_issued - m_popped) < DEPTH);
      vectors++;
      if (bus.mem_en !== exp_en) begin
        miscompares++;
        $display("[TB] FAIL mem_en_rule cyc=%0d got %b want %b", cyc, bus.mem_en, exp_en);
      end
      vectors++;
      if ((m_issued - m_popped) > DEPTH) begin
        miscompares++;
        $display("[TB] FAIL occupancy cyc=%0d got %0d want <=%0d", cyc, m_issued - m_popped, DEPTH);
      end
      if (!bus.mem_en) begin
        vectors++;
        if (bus.mem_addr !== m_last_addr) begin
          miscompares++;
          $display("[TB] FAIL mem_addr_hold cyc=%0d got %h want %h", cyc, bus.mem_addr, m_last_addr);
        end
      end
      if (stall_prev) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== stall_data) begin
          miscompares++;
          $display("[TB] FAIL stall_hold cyc=%0d got v=%b d=%h want v=1 d=%h", cyc, bus.out_valid, bus.out_data, stall_data);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;

      if (bus.mem_en) begin
        iss_q.push_back(bus.mem_addr);
        iss_cyc_q.push_back(cyc);
        m_last_addr = bus.mem_addr;
        m_issued++;
        m_len_issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
        beat_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
        beat_cyc_q.push_back(cyc);
        if (m_beat % 4 == 3) m_popped++;
        if (m_beat == 4 * m_len - 1) m_run = 0;
        m_beat++;
      end
      if (bus.done) done_cyc_q.push_back(cyc);
      if (bus.cmd_valid && bus.cmd_ready) begin
        acc_cyc_q.push_back(cyc);
        acc_busy_q.push_back(bus.busy);
        m_len = int'(bus.cmd_len);
        m_len_issued = 0;
        m_beat = 0;
        m_run = (bus.cmd_len != '0);
      end
    end
  end

  task automatic clear_obs();
    iss_q.delete(); iss_cyc_q.delete(); beat_q.delete(); last_q.delete();
    beat_cyc_q.delete(); acc_cyc_q.delete(); acc_busy_q.delete(); done_cyc_q.delete();
    exp_addr_q.delete(); exp_beat_q.delete(); exp_last_q.delete();
  endtask

  // Reference model: words addr..addr+len-1 (mod 2^AW), four lanes each.
  task automatic model_cmd(input logic [AW-1:0] a, input int len);
    logic [AW-1:0] wa;
    logic [63:0]   word;
    for (int w = 0; w < len; w++) begin
      wa = a + AW'(w);
      word = mem[wa];
      exp_addr_q.push_back(wa);
      for (int l = 0; l < 4; l++) begin
        exp_beat_q.push_back(word[16*l +: 16]);
        exp_last_q.push_back((w == len - 1) && (l == 3));
      end
    end
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input int len, output bit ok);
    ok = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = LENW'(len);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 0;
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1; break; end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    #1 rstn = 1'b0;
    @(negedge clk);
    vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
    vectors++; if (bus.mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_en got %b want 0", bus.mem_en); end
    vectors++; if (bus.mem_addr !== '0) begin miscompares++; $display("[TB] FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_out_data got %h want 0", bus.out_data); end
    vectors++; if (bus.out_last !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_last got %b want 0", bus.out_last); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_single_word();
    bit ok, ok2;
    logic [15:0] want [4];
    want = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    mem[11'h005] = 64'h4444_3333_2222_1111;
    clear_obs();
    ready_mode = 0;
    send_cmd(11'h005, 1, ok);
    wait_done(200, ok2);
    vectors++; if (!(ok && ok2)) begin miscompares++; $display("[TB] FAIL single_complete got accept=%b done=%b want 1 1", ok, ok2); end
    vectors++; if (iss_q.size() != 1 || iss_q[0] !== 11'h005) begin miscompares++; $display("[TB] FAIL single_reads got n=%0d addr=%h want n=1 addr=005", iss_q.size(), iss_q[0]); end
    vectors++; if (beat_q.size() != 4) begin miscompares++; $display("[TB] FAIL single_beat_count got %0d want 4", beat_q.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (beat_q[i] !== want[i] || last_q[i] !== (i == 3)) begin
        miscompares++;
        $display("[TB] FAIL single_beat[%0d] got %h last=%b want %h last=%b", i, beat_q[i], last_q[i], want[i], (i == 3));
      end
    end
    for (int i = 1; i < 4; i++) begin
      vectors++;
      if (beat_cyc_q[i] - beat_cyc_q[i-1] != 1) begin miscompares++; $display("[TB] FAIL single_gap[%0d] got %0d want 1", i, beat_cyc_q[i] - beat_cyc_q[i-1]); end
    end
    vectors++; if (iss_cyc_q[0] - acc_cyc_q[0] != 1) begin miscompares++; $display("[TB] FAIL single_issue_lat got %0d want 1", iss_cyc_q[0] - acc_cyc_q[0]); end
    vectors++; if (beat_cyc_q[0] - acc_cyc_q[0] != 3) begin miscompares++; $display("[TB] FAIL single_valid_lat got %0d want 3", beat_cyc_q[0] - acc_cyc_q[0]); end
    vectors++; if (done_cyc_q.size() != 1 || done_cyc_q[0] - beat_cyc_q[3] != 1) begin miscompares++; $display("[TB] FAIL single_done got n=%0d dt=%0d want n=1 dt=1", done_cyc_q.size(), done_cyc_q[0] - beat_cyc_q[3]); end
  endtask

  task automatic test_streaming();
    bit ok, ok2;
    clear_obs();
    ready_mode = 0;
    model_cmd(11'h100, 8);
    send_cmd(11'h100, 8, ok);
    wait_done(400, ok2);
    vectors++; if (!(ok && ok2)) begin miscompares++; $display("[TB] FAIL stream_complete got accept=%b done=%b want 1 1", ok, ok2); end
    vectors++; if (iss_q.size() != 8) begin miscompares++; $display("[TB] FAIL stream_read_count got %0d want 8", iss_q.size()); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (iss_q[i] !== AW'(11'h100 + i)) begin miscompares++; $display("[TB] FAIL stream_addr[%0d] got %h want %h", i, iss_q[i], AW'(11'h100 + i)); end
    end
    vectors++; if (beat_q.size() != 32) begin miscompares++; $display("[TB] FAIL stream_beat_count got %0d want 32", beat_q.size()); end
    foreach (exp_beat_q[i]) begin
      vectors++;
      if (beat_q[i] !== exp_beat_q[i] || last_q[i] !== exp_last_q[i]) begin
        miscompares++;
        $display("[TB] FAIL stream_beat[%0d] got %h last=%b want %h last=%b", i, beat_q[i], last_q[i], exp_beat_q[i], exp_last_q[i]);
      end
      if (i > 0) begin
        vectors++;
        if (beat_cyc_q[i] - beat_cyc_q[i-1] != 1) begin miscompares++; $display("[TB] FAIL stream_gap[%0d] got %0d want 1", i, beat_cyc_q[i] - beat_cyc_q[i-1]); end
      end
    end
  endtask

  task automatic test_wrap();
    bit ok, ok2;
    clear_obs();
    ready_mode = 2;
    model_cmd(11'h7FE, 4);
    send_cmd(11'h7FE, 4, ok);
    wait_done(600, ok2);
    ready_mode = 0;
    vectors++; if (!(ok && ok2)) begin miscompares++; $display("[TB] FAIL wrap_complete got accept=%b done=%b want 1 1", ok, ok2); end
    vectors++; if (iss_q.size() != 4) begin miscompares++; $display("[TB] FAIL wrap_read_count got %0d want 4", iss_q.size()); end
    foreach (exp_addr_q[i]) begin
      vectors++; if (iss_q[i] !== exp_addr_q[i]) begin miscompares++; $display("[TB] FAIL wrap_addr[%0d] got %h want %h", i, iss_q[i], exp_addr_q[i]); end
    end
    vectors++; if (beat_q.size() != 16) begin miscompares++; $display("[TB] FAIL wrap_beat_count got %0d want 16", beat_q.size()); end
    foreach (exp_beat_q[i]) begin
      vectors++;
      if (beat_q[i] !== exp_beat_q[i] || last_q[i] !== exp_last_q[i]) begin
        miscompares++;
        $display("[TB] FAIL wrap_beat[%0d] got %h last=%b want %h last=%b", i, beat_q[i], last_q[i], exp_beat_q[i], exp_last_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, ok2;
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 2**AW - 1));
    clear_obs();
    rphase = 0;
    ready_mode = 1;
    model_cmd(a, 3);
    send_cmd(a, 3, ok);
    wait_done(600, ok2);
    ready_mode = 0;
    vectors++; if (!(ok && ok2)) begin miscompares++; $display("[TB] FAIL bp_complete got accept=%b done=%b want 1 1", ok, ok2); end
    vectors++; if (iss_q.size() != 3) begin miscompares++; $display("[TB] FAIL bp_read_count got %0d want 3", iss_q.size()); end
    vectors++; if (beat_q.size() != 12) begin miscompares++; $display("[TB] FAIL bp_beat_count got %0d want 12", beat_q.size()); end
    foreach (exp_beat_q[i]) begin
      vectors++;
      if (beat_q[i] !== exp_beat_q[i] || last_q[i] !== exp_last_q[i]) begin
        miscompares++;
        $display("[TB] FAIL bp_beat[%0d] got %h last=%b want %h last=%b", i, beat_q[i], last_q[i], exp_beat_q[i], exp_last_q[i]);
      end
    end
  endtask

  task automatic test_zero_len_gating();
    bit ok, ok2, okb;
    logic [AW-1:0] a, b;
    a = AW'($urandom_range(0, 2**AW - 1));
    b = AW'($urandom_range(0, 2**AW - 1));
    clear_obs();
    ready_mode = 0;
    send_cmd(a, 0, ok);
    wait_done(50, ok2);
    vectors++; if (!(ok && ok2)) begin miscompares++; $display("[TB] FAIL zero_complete got accept=%b done=%b want 1 1", ok, ok2); end
    vectors++; if (iss_q.size() != 0 || beat_q.size() != 0) begin miscompares++; $display("[TB] FAIL zero_activity got reads=%0d beats=%0d want 0 0", iss_q.size(), beat_q.size()); end
    vectors++; if (done_cyc_q.size() != 1 || done_cyc_q[0] - acc_cyc_q[0] != 1) begin miscompares++; $display("[TB] FAIL zero_done got n=%0d dt=%0d want n=1 dt=1", done_cyc_q.size(), done_cyc_q[0] - acc_cyc_q[0]); end

    // Second command offered continuously while a len=2 transfer runs.
    clear_obs();
    model_cmd(a, 2);
    model_cmd(b, 1);
    ok = 0; okb = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_len = LENW'(2);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    bus.cmd_addr = b; bus.cmd_len = LENW'(1);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin okb = 1; break; end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    wait_done(200, ok2);
    vectors++; if (!(ok && okb && ok2)) begin miscompares++; $display("[TB] FAIL gate_complete got a=%b b=%b done=%b want 1 1 1", ok, okb, ok2); end
    vectors++; if (acc_cyc_q.size() != 2 || acc_busy_q[1] !== 1'b0) begin miscompares++; $display("[TB] FAIL gate_accepts got n=%0d busy=%b want n=2 busy=0", acc_cyc_q.size(), acc_busy_q[1]); end
    vectors++; if (done_cyc_q.size() != 2 || acc_cyc_q[1] - done_cyc_q[0] != 1) begin miscompares++; $display("[TB] FAIL gate_timing got dones=%0d dt=%0d want 2 1", done_cyc_q.size(), acc_cyc_q[1] - done_cyc_q[0]); end
    vectors++; if (beat_q.size() != 12) begin miscompares++; $display("[TB] FAIL gate_beat_count got %0d want 12", beat_q.size()); end
    foreach (exp_beat_q[i]) begin
      vectors++;
      if (beat_q[i] !== exp_beat_q[i] || last_q[i] !== exp_last_q[i]) begin
        miscompares++;
        $display("[TB] FAIL gate_beat[%0d] got %h last=%b want %h last=%b", i, beat_q[i], last_q[i], exp_beat_q[i], exp_last_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2, got5;
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 2**AW - 1));
    clear_obs();
    ready_mode = 0;
    send_cmd(a, 4, ok);
    got5 = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (beat_q.size() >= 5) begin got5 = 1; break; end
    end
    vectors++; if (!(ok && got5)) begin miscompares++; $display("[TB] FAIL rmid_progress got accept=%b beats5=%b want 1 1", ok, got5); end
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    vectors++; if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_cmd_ready got %b want 1", bus.cmd_ready); end
    vectors++; if (bus.mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_mem_en got %b want 0", bus.mem_en); end
    vectors++; if (bus.mem_addr !== '0) begin miscompares++; $display("[TB] FAIL rmid_mem_addr got %h want 0", bus.mem_addr); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 16'h0) begin miscompares++; $display("[TB] FAIL rmid_out_data got %h want 0", bus.out_data); end
    vectors++; if (bus.out_last !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_out_last got %b want 0", bus.out_last); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_busy got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_done got %b want 0", bus.done); end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    vectors++; if (done_cyc_q.size() != 0) begin miscompares++; $display("[TB] FAIL rmid_no_done got %0d pulses want 0", done_cyc_q.size()); end

    a = AW'($urandom_range(0, 2**AW - 1));
    clear_obs();
    model_cmd(a, 1);
    send_cmd(a, 1, ok);
    wait_done(200, ok2);
    vectors++; if (!(ok && ok2)) begin miscompares++; $display("[TB] FAIL rmid_fresh_complete got accept=%b done=%b want 1 1", ok, ok2); end
    vectors++; if (beat_q.size() != 4 || iss_q.size() != 1) begin miscompares++; $display("[TB] FAIL rmid_fresh_count got beats=%0d reads=%0d want 4 1", beat_q.size(), iss_q.size()); end
    foreach (exp_beat_q[i]) begin
      vectors++;
      if (beat_q[i] !== exp_beat_q[i] || last_q[i] !== exp_last_q[i]) begin
        miscompares++;
        $display("[TB] FAIL rmid_fresh_beat[%0d] got %h last=%b want %h last=%b", i, beat_q[i], last_q[i], exp_beat_q[i], exp_last_q[i]);
      end
    end
  endtask

  // Hard stop in case a bounded wait is ever bypassed.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = {$urandom(), $urandom()};
    end
    test_reset();
    test_single_word();
    test_streaming();
    test_wrap();
    test_backpressure();
    test_zero_len_gating();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
